// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side hazard scheduler: EX/MEM/WB destination scoreboard, issue/stall/squash, forward selects, halt drain and statistics.
// Build option: define FORWARDING_EN to forward EX/MEM results and stall only on load-use.
module pipeline_hazard_ctrl #(
  parameter int REGISTERWIDTH = 5,
  parameter int CNTWIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REGISTERWIDTH-1:0] id_rs,
  input  logic [REGISTERWIDTH-1:0] id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [REGISTERWIDTH-1:0] id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     id_halt,
  input  logic                     ex_branch_taken,
  output logic                     stall,
  output logic                     issue,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic                     halted,
  output logic [CNTWIDTH-1:0]      stall_count,
  output logic [CNTWIDTH-1:0]      hazard_count,
  output logic [CNTWIDTH-1:0]      cycle_count
);

  logic                     ex_v_q, ex_v_d, ex_wr_q, ex_wr_d, ex_halt_q, ex_halt_d;
  logic                     ex_ld_q, ex_ld_d;
  logic [REGISTERWIDTH-1:0] ex_rd_q, ex_rd_d;
  logic                     mem_v_q, mem_v_d, mem_wr_q, mem_wr_d, mem_halt_q, mem_halt_d;
  logic [REGISTERWIDTH-1:0] mem_rd_q, mem_rd_d;
  logic                     wb_halt_q, wb_halt_d;
  logic                     halted_q, halted_d;
  logic                     halt_seen_q, halt_seen_d;
  logic                     stalled_q, stalled_d;
  logic [1:0]               fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNTWIDTH-1:0]      stall_count_q, stall_count_d;
  logic [CNTWIDTH-1:0]      hazard_count_q, hazard_count_d;
  logic [CNTWIDTH-1:0]      cycle_count_q, cycle_count_d;

  logic ex_a, ex_b, mem_a, mem_b, hazard;

  function automatic logic hit(input logic v, input logic wr,
                               input logic [REGISTERWIDTH-1:0] rd,
                               input logic [REGISTERWIDTH-1:0] src, input logic use_src);
    return use_src & v & wr & (rd != '0) & (rd == src);
  endfunction

  // WB is never a hazard source because the register file is write-first.
  always_comb begin
    ex_a  = hit(ex_v_q, ex_wr_q, ex_rd_q, id_rs, id_use_rs);
    ex_b  = hit(ex_v_q, ex_wr_q, ex_rd_q, id_rt, id_use_rt);
    mem_a = hit(mem_v_q, mem_wr_q, mem_rd_q, id_rs, id_use_rs);
    mem_b = hit(mem_v_q, mem_wr_q, mem_rd_q, id_rt, id_use_rt);
`ifdef FORWARDING_EN
    hazard = ex_ld_q & (ex_a | ex_b);
`else
    hazard = ex_a | ex_b | mem_a | mem_b;
`endif
    stall  = id_valid & hazard & ~ex_branch_taken & ~halt_seen_q;
    issue  = id_valid & ~stall & ~ex_branch_taken & ~halt_seen_q;
    halted = halted_q | wb_halt_q;
  end

  always_comb begin
    ex_v_d     = issue;
    ex_rd_d    = issue ? id_rd : '0;
    ex_wr_d    = issue & id_reg_write;
    ex_ld_d    = issue & id_is_load;
    ex_halt_d  = issue & id_halt;
    mem_v_d    = ex_v_q;
    mem_rd_d   = ex_rd_q;
    mem_wr_d   = ex_wr_q;
    mem_halt_d = ex_v_q & ex_halt_q;
    wb_halt_d  = mem_v_q & mem_halt_q;
    halted_d   = halted;
    halt_seen_d = halt_seen_q | (issue & id_halt);
    stalled_d  = stall;
    fwd_a_d    = 2'b00;
    fwd_b_d    = 2'b00;
`ifdef FORWARDING_EN
    if (issue) begin
      fwd_a_d = ex_a ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
      fwd_b_d = ex_b ? 2'b01 : (mem_b ? 2'b10 : 2'b00);
    end
`endif
    stall_count_d  = stall_count_q;
    hazard_count_d = hazard_count_q;
    cycle_count_d  = cycle_count_q;
    if (stall && stall_count_q != '1)
      stall_count_d = stall_count_q + CNTWIDTH'(1);
    // A stalled instruction still counts once when it finally issues.
    if (issue && (ex_a || ex_b || mem_a || mem_b || stalled_q) && hazard_count_q != '1)
      hazard_count_d = hazard_count_q + CNTWIDTH'(1);
    if (!halted && cycle_count_q != '1)
      cycle_count_d = cycle_count_q + CNTWIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q <= 1'b0; ex_rd_q <= '0; ex_wr_q <= 1'b0; ex_ld_q <= 1'b0; ex_halt_q <= 1'b0;
      mem_v_q <= 1'b0; mem_rd_q <= '0; mem_wr_q <= 1'b0; mem_halt_q <= 1'b0;
      wb_halt_q      <= 1'b0;
      halted_q       <= 1'b0;
      halt_seen_q    <= 1'b0;
      stalled_q      <= 1'b0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
      stall_count_q  <= '0;
      hazard_count_q <= '0;
      cycle_count_q  <= '0;
    end else begin
      ex_v_q <= ex_v_d; ex_rd_q <= ex_rd_d; ex_wr_q <= ex_wr_d; ex_ld_q <= ex_ld_d; ex_halt_q <= ex_halt_d;
      mem_v_q <= mem_v_d; mem_rd_q <= mem_rd_d; mem_wr_q <= mem_wr_d; mem_halt_q <= mem_halt_d;
      wb_halt_q      <= wb_halt_d;
      halted_q       <= halted_d;
      halt_seen_q    <= halt_seen_d;
      stalled_q      <= stalled_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_count_q  <= stall_count_d;
      hazard_count_q <= hazard_count_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign stall_count  = stall_count_q;
  assign hazard_count = hazard_count_q;
  assign cycle_count  = cycle_count_q;

endmodule
